// File: rtl/instruction_fetch.sv
// Fetch stage of the 5-stage RV32I pipeline: owns the PC, drives the
// combinational instruction memory and registers the fetched word into IF/ID.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  output logic             if_id_valid,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc_plus4,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc_plus4;
  logic              valid_d;
  logic [XLEN-1:0]   instr_d;
  logic [XLEN-1:0]   id_pc_d;
  logic [XLEN-1:0]   id_pc_plus4_d;
  logic              halted_d;
  logic [CNT_W-1:0]  count_d;

  // Redirect targets are word aligned; the low bits carry no information.
  logic unused_target_lsbs;
  assign unused_target_lsbs = &{1'b0, redirect_target[1:0]};

  // The memory address is the PC itself, with nothing else on the path.
  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + XLEN'(4);

  // State and pipeline register update; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      halted         <= 1'b0;
      fetch_count    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      if_id_valid    <= valid_d;
      if_id_instr    <= instr_d;
      if_id_pc       <= id_pc_d;
      if_id_pc_plus4 <= id_pc_plus4_d;
      halted         <= halted_d;
      fetch_count    <= count_d;
    end
  end

  // Next-state and next-register values: redirect > stall > state action.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    valid_d       = if_id_valid;
    instr_d       = if_id_instr;
    id_pc_d       = if_id_pc;
    id_pc_plus4_d = if_id_pc_plus4;
    halted_d      = halted;
    count_d       = fetch_count;

    if (redirect_valid) begin
      pc_d     = {redirect_target[31:2], 2'b00};
      valid_d  = 1'b0;
      instr_d  = NOP_INSTR;
      state_d  = RUN;
      halted_d = 1'b0;
    end else if (!stall) begin
      case (state_q)
        BOOT: begin
          valid_d = 1'b0;
          state_d = RUN;
        end
        RUN: begin
          valid_d       = 1'b1;
          instr_d       = imem_rdata;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          pc_d          = pc_plus4;
          count_d       = fetch_count + CNT_W'(1);
          if (imem_rdata == HALT_INSTR) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        end
        HALT: begin
          valid_d  = 1'b0;
          instr_d  = NOP_INSTR;
          halted_d = 1'b1;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid, halted;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_count;

  logic [31:0] u5_addr, u5_rdata;
  logic        u5_valid, u5_halted;
  logic [31:0] u5_instr, u5_pc, u5_pc4, u5_count;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:2]];
  assign u5_rdata   = mem[u5_addr[9:2]];

  instruction_fetch dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .halted(halted), .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u5 (
    .clk(clk), .reset(reset),
    .imem_addr(u5_addr), .imem_rdata(u5_rdata),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_target(32'h0),
    .if_id_valid(u5_valid), .if_id_instr(u5_instr), .if_id_pc(u5_pc),
    .if_id_pc_plus4(u5_pc4), .halted(u5_halted), .fetch_count(u5_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, halted, fetch_count, imem_addr} !==
        {1'b0, 32'h13, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0})
      $display("FAIL reset_state act=%h/%h/%h/%h/%b/%0d/%h exp=0/13/0/0/0/0/0",
               if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, halted, fetch_count, imem_addr);
    else n_pass++;
  endtask

  task automatic test_sequential();
    step();
    n_checks++;
    if ({if_id_valid, imem_addr, fetch_count} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL boot_cycle act=%b/%h/%0d exp=0/0/0", if_id_valid, imem_addr, fetch_count);
    else n_pass++;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, imem_addr} !==
        {1'b1, 32'hC0DE_0000, 32'h0, 32'h4, 32'h4})
      $display("FAIL fetch_A act=%b/%h/%h/%h/%h exp=1/c0de0000/0/4/4",
               if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, imem_addr);
    else n_pass++;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, imem_addr, fetch_count} !==
        {1'b1, 32'hC0DE_0001, 32'h4, 32'h8, 32'd2})
      $display("FAIL fetch_B act=%b/%h/%h/%h/%0d exp=1/c0de0001/4/8/2",
               if_id_valid, if_id_instr, if_id_pc, imem_addr, fetch_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({if_id_valid, if_id_instr, if_id_pc, imem_addr, fetch_count} !==
          {1'b1, 32'hC0DE_0001, 32'h4, 32'h8, 32'd2})
        $display("FAIL stall_hold%0d act=%b/%h/%h/%h/%0d exp=1/c0de0001/4/8/2",
                 i, if_id_valid, if_id_instr, if_id_pc, imem_addr, fetch_count);
      else n_pass++;
    end
    stall = 1'b0;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, imem_addr, fetch_count} !==
        {1'b1, 32'hC0DE_0002, 32'h8, 32'hC, 32'hC, 32'd3})
      $display("FAIL stall_release act=%b/%h/%h/%h/%h/%0d exp=1/c0de0002/8/c/c/3",
               if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, imem_addr, fetch_count);
    else n_pass++;
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0042;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, imem_addr, fetch_count} !==
        {1'b0, 32'h13, 32'h8, 32'h40, 32'd3})
      $display("FAIL redirect_flush act=%b/%h/%h/%h/%0d exp=0/13/8/40/3",
               if_id_valid, if_id_instr, if_id_pc, imem_addr, fetch_count);
    else n_pass++;
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, imem_addr, fetch_count} !==
        {1'b1, 32'hC0DE_0010, 32'h40, 32'h44, 32'h44, 32'd4})
      $display("FAIL redirect_fetch act=%b/%h/%h/%h/%h/%0d exp=1/c0de0010/40/44/44/4",
               if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, imem_addr, fetch_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0100;
    step();
    n_checks++;
    if ({if_id_valid, imem_addr} !== {1'b0, 32'h100})
      $display("FAIL b2b_first act=%b/%h exp=0/100", if_id_valid, imem_addr);
    else n_pass++;
    redirect_target = 32'h0000_0203;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, imem_addr, fetch_count} !== {1'b0, 32'h13, 32'h200, 32'd4})
      $display("FAIL b2b_second act=%b/%h/%h/%0d exp=0/13/200/4",
               if_id_valid, if_id_instr, imem_addr, fetch_count);
    else n_pass++;
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, fetch_count} !== {1'b1, 32'hC0DE_0080, 32'h200, 32'd5})
      $display("FAIL b2b_fetch act=%b/%h/%h/%0d exp=1/c0de0080/200/5",
               if_id_valid, if_id_instr, if_id_pc, fetch_count);
    else n_pass++;
  endtask

  task automatic test_halt();
    mem[2] = 32'h0010_0073;
    do_reset();
    step();
    step();
    step();
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, halted, imem_addr, fetch_count} !==
        {1'b1, 32'h0010_0073, 32'h8, 1'b1, 32'hC, 32'd3})
      $display("FAIL halt_capture act=%b/%h/%h/%b/%h/%0d exp=1/00100073/8/1/c/3",
               if_id_valid, if_id_instr, if_id_pc, halted, imem_addr, fetch_count);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({if_id_valid, if_id_instr, if_id_pc, halted, imem_addr, fetch_count} !==
          {1'b0, 32'h13, 32'h8, 1'b1, 32'hC, 32'd3})
        $display("FAIL halt_hold%0d act=%b/%h/%h/%b/%h/%0d exp=0/13/8/1/c/3",
                 i, if_id_valid, if_id_instr, if_id_pc, halted, imem_addr, fetch_count);
      else n_pass++;
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h0;
    step();
    n_checks++;
    if ({if_id_valid, halted, imem_addr, fetch_count} !== {1'b0, 1'b0, 32'h0, 32'd3})
      $display("FAIL halt_redirect act=%b/%b/%h/%0d exp=0/0/0/3",
               if_id_valid, halted, imem_addr, fetch_count);
    else n_pass++;
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, halted, fetch_count} !==
        {1'b1, 32'hC0DE_0000, 32'h0, 1'b0, 32'd4})
      $display("FAIL halt_resume act=%b/%h/%h/%b/%0d exp=1/c0de0000/0/0/4",
               if_id_valid, if_id_instr, if_id_pc, halted, fetch_count);
    else n_pass++;
    mem[2] = 32'hC0DE_0002;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    n_checks++;
    if ({u5_valid, u5_addr, u5_count, u5_halted} !== {1'b0, 32'hFFFF_FFFC, 32'd0, 1'b0})
      $display("FAIL wrap_reset act=%b/%h/%0d/%b exp=0/fffffffc/0/0",
               u5_valid, u5_addr, u5_count, u5_halted);
    else n_pass++;
    step();
    step();
    n_checks++;
    if ({u5_valid, u5_instr, u5_pc, u5_pc4, u5_addr} !==
        {1'b1, 32'hC0DE_00FF, 32'hFFFF_FFFC, 32'h0, 32'h0})
      $display("FAIL wrap_first act=%b/%h/%h/%h/%h exp=1/c0de00ff/fffffffc/0/0",
               u5_valid, u5_instr, u5_pc, u5_pc4, u5_addr);
    else n_pass++;
    step();
    n_checks++;
    if ({u5_valid, u5_instr, u5_pc, u5_pc4, u5_count} !==
        {1'b1, 32'hC0DE_0000, 32'h0, 32'h4, 32'd2})
      $display("FAIL wrap_second act=%b/%h/%h/%h/%0d exp=1/c0de0000/0/4/2",
               u5_valid, u5_instr, u5_pc, u5_pc4, u5_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    step();
    step();
    step();
    n_checks++;
    if ({if_id_pc, fetch_count} !== {32'h4, 32'd2})
      $display("FAIL pre_reset_run act=%h/%0d exp=4/2", if_id_pc, fetch_count);
    else n_pass++;
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, halted, fetch_count, imem_addr} !==
        {1'b0, 32'h13, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0})
      $display("FAIL midrun_reset act=%b/%h/%h/%h/%b/%0d/%h exp=0/13/0/0/0/0/0",
               if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4, halted, fetch_count, imem_addr);
    else n_pass++;
    reset = 1'b0;
    redirect_valid = 1'b0;
    step();
    n_checks++;
    if ({if_id_valid, imem_addr, fetch_count} !== {1'b0, 32'h0, 32'd0})
      $display("FAIL midrun_boot act=%b/%h/%0d exp=0/0/0", if_id_valid, imem_addr, fetch_count);
    else n_pass++;
    step();
    n_checks++;
    if ({if_id_valid, if_id_instr, if_id_pc, fetch_count} !== {1'b1, 32'hC0DE_0000, 32'h0, 32'd1})
      $display("FAIL midrun_fetch act=%b/%h/%h/%0d exp=1/c0de0000/0/1",
               if_id_valid, if_id_instr, if_id_pc, fetch_count);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_halt();
    test_pc_wrap();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
